// File: rtl/axi_ram_initiator.sv
// rtl/axi_ram_initiator.sv - AXI-style burst slave driving the single-port byte-masked on-chip RAM.
// One RAM access per beat; reads pass through a 2-entry skid FIFO to absorb r_ready backpressure.
module axi_ram_initiator #(
  parameter int ADDR_BITS     = 14,
  parameter int RAM_ADDR_BITS = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     axi_arw_valid,
  output logic                     axi_arw_ready,
  input  logic [ADDR_BITS-1:0]     axi_arw_payload_addr,
  input  logic                     axi_arw_payload_id,
  input  logic [7:0]               axi_arw_payload_len,
  input  logic [2:0]               axi_arw_payload_size,
  input  logic [1:0]               axi_arw_payload_burst,
  input  logic                     axi_arw_payload_write,
  input  logic                     axi_w_valid,
  output logic                     axi_w_ready,
  input  logic [31:0]              axi_w_payload_data,
  input  logic [3:0]               axi_w_payload_strb,
  input  logic                     axi_w_payload_last,
  output logic                     axi_b_valid,
  input  logic                     axi_b_ready,
  output logic                     axi_b_payload_id,
  output logic                     axi_r_valid,
  input  logic                     axi_r_ready,
  output logic [31:0]              axi_r_payload_data,
  output logic                     axi_r_payload_id,
  output logic                     axi_r_payload_last,
  output logic                     ram_en,
  output logic                     ram_wr,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [3:0]               ram_mask,
  output logic [31:0]              ram_wrData,
  input  logic [31:0]              ram_rdData
);

  typedef enum logic [1:0] {IDLE, WRITE, WRITE_RESP, READ} state_t;

  state_t                state, state_nxt;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [ADDR_BITS-1:0]  addr_step;
  logic                  id_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic [8:0]            beat_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [32:0]           fifo_mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            fifo_count;

  logic                  arw_fire;
  logic                  w_fire;
  logic                  issue;
  logic                  pop;
  logic                  last_beat;
  logic                  wrap_ok;
  logic [ADDR_BITS-1:0]  addr_inc;
  logic [ADDR_BITS-1:0]  wrap_mask;
  logic [2:0]            occ_after_pop;

  // size and w_last are deliberately unused: beats are always 4 bytes and the counter ends bursts
  logic                  unused_ok;
  assign unused_ok = ^{axi_arw_payload_size, axi_w_payload_last};

  assign arw_fire  = axi_arw_valid && axi_arw_ready;
  assign w_fire    = (state == WRITE) && axi_w_valid;
  assign pop       = axi_r_valid && axi_r_ready;
  assign last_beat = (beat_q == {1'b0, len_q});

  assign occ_after_pop = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state == READ) && (beat_q <= {1'b0, len_q}) && (occ_after_pop < 3'd2);

  assign wrap_ok   = (burst_q == 2'b10) &&
                     ((len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15));
  assign addr_inc  = addr_q + ADDR_BITS'(4);
  assign wrap_mask = ADDR_BITS'({len_q[3:0], 2'b11});

  always_comb begin
    addr_step = addr_inc;
    if (burst_q == 2'b00)
      addr_step = addr_q;
    else if (wrap_ok)
      addr_step = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (axi_arw_valid) state_nxt = axi_arw_payload_write ? WRITE : READ;
      WRITE:      if (w_fire && last_beat) state_nxt = WRITE_RESP;
      WRITE_RESP: if (axi_b_ready) state_nxt = IDLE;
      READ:       if (pop && axi_r_payload_last) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  assign axi_arw_ready      = (state == IDLE);
  assign axi_w_ready        = (state == WRITE);
  assign axi_b_valid        = (state == WRITE_RESP);
  assign axi_b_payload_id   = id_q;
  assign axi_r_valid        = (fifo_count != 2'd0);
  assign axi_r_payload_data = fifo_mem[rd_ptr][32:1];
  assign axi_r_payload_last = fifo_mem[rd_ptr][0];
  assign axi_r_payload_id   = id_q;

  assign ram_en     = w_fire || issue;
  assign ram_wr     = w_fire;
  assign ram_addr   = addr_q[ADDR_BITS-1:2];
  assign ram_mask   = (state == WRITE) ? axi_w_payload_strb : 4'hF;
  assign ram_wrData = axi_w_payload_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q          <= '0;
      id_q            <= 1'b0;
      len_q           <= 8'd0;
      burst_q         <= 2'b00;
      beat_q          <= 9'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_mem[0]     <= '0;
      fifo_mem[1]     <= '0;
      rd_ptr          <= 1'b0;
      wr_ptr          <= 1'b0;
      fifo_count      <= 2'd0;
    end else begin
      if (arw_fire) begin
        addr_q  <= axi_arw_payload_addr;
        id_q    <= axi_arw_payload_id;
        len_q   <= axi_arw_payload_len;
        burst_q <= axi_arw_payload_burst;
        beat_q  <= 9'd0;
      end else if (w_fire || issue) begin
        addr_q <= addr_step;
        beat_q <= beat_q + 9'd1;
      end
      // RAM data returns one cycle after issue and lands in the FIFO then
      inflight_q      <= issue;
      inflight_last_q <= last_beat;
      if (inflight_q) begin
        fifo_mem[wr_ptr] <= {ram_rdData, inflight_last_q};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_axi_ram_initiator.sv
// tb/tb_axi_ram_initiator.sv - scoreboard bench for axi_ram_initiator with a 1-cycle RAM model.
module tb_axi_ram_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        axi_arw_valid, axi_arw_ready;
  logic [13:0] axi_arw_payload_addr;
  logic        axi_arw_payload_id;
  logic [7:0]  axi_arw_payload_len;
  logic [2:0]  axi_arw_payload_size;
  logic [1:0]  axi_arw_payload_burst;
  logic        axi_arw_payload_write;
  logic        axi_w_valid, axi_w_ready;
  logic [31:0] axi_w_payload_data;
  logic [3:0]  axi_w_payload_strb;
  logic        axi_w_payload_last;
  logic        axi_b_valid, axi_b_ready, axi_b_payload_id;
  logic        axi_r_valid, axi_r_ready;
  logic [31:0] axi_r_payload_data;
  logic        axi_r_payload_id, axi_r_payload_last;
  logic        ram_en, ram_wr;
  logic [11:0] ram_addr;
  logic [3:0]  ram_mask;
  logic [31:0] ram_wrData;
  logic [31:0] ram_rdData;

  always #5 clk = ~clk;

  axi_ram_initiator #(.ADDR_BITS(14), .RAM_ADDR_BITS(12)) dut (
    .clk(clk), .reset(reset),
    .axi_arw_valid(axi_arw_valid), .axi_arw_ready(axi_arw_ready),
    .axi_arw_payload_addr(axi_arw_payload_addr), .axi_arw_payload_id(axi_arw_payload_id),
    .axi_arw_payload_len(axi_arw_payload_len), .axi_arw_payload_size(axi_arw_payload_size),
    .axi_arw_payload_burst(axi_arw_payload_burst), .axi_arw_payload_write(axi_arw_payload_write),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_w_payload_data(axi_w_payload_data), .axi_w_payload_strb(axi_w_payload_strb),
    .axi_w_payload_last(axi_w_payload_last),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_payload_id(axi_b_payload_id),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .axi_r_payload_data(axi_r_payload_data), .axi_r_payload_id(axi_r_payload_id),
    .axi_r_payload_last(axi_r_payload_last),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_mask(ram_mask),
    .ram_wrData(ram_wrData), .ram_rdData(ram_rdData)
  );

  logic [31:0] mem    [4096];
  logic [31:0] shadow [4096];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) begin
        for (int b = 0; b < 4; b++)
          if (ram_mask[b]) mem[ram_addr][8*b +: 8] <= ram_wrData[8*b +: 8];
      end else begin
        ram_rdData <= mem[ram_addr];
      end
    end
  end

  typedef struct { logic wr; logic [11:0] a; logic [3:0] m; logic [31:0] d; } ram_t;
  typedef struct { logic [31:0] d; logic last; logic id; } r_t;
  ram_t ram_q[$];
  r_t   r_q[$];
  logic b_q[$];
  ram_t re;
  r_t   rx;
  logic bx;

  int checks = 0, passes = 0;
  int r_pops = 0, occ = 0, max_occ = 0;
  bit rr_toggle = 0;
  logic [11:0] wa [8];
  logic [31:0] wd [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      occ = 0;
    end else begin
      if (ram_en) begin
        if (ram_q.size() == 0) check("ram_unexpected_access", {20'd0, ram_addr}, 32'hFFFF_FFFF);
        else begin
          re = ram_q.pop_front();
          check("ram_wr", {31'd0, ram_wr}, {31'd0, re.wr});
          check("ram_addr", {20'd0, ram_addr}, {20'd0, re.a});
          check("ram_mask", {28'd0, ram_mask}, {28'd0, re.m});
          if (re.wr) check("ram_wrData", ram_wrData, re.d);
        end
      end
      if (axi_r_valid && axi_r_ready) begin
        r_pops++;
        if (r_q.size() == 0) check("r_unexpected_beat", axi_r_payload_data, 32'hFFFF_FFFF);
        else begin
          rx = r_q.pop_front();
          check("r_data", axi_r_payload_data, rx.d);
          check("r_last", {31'd0, axi_r_payload_last}, {31'd0, rx.last});
          check("r_id", {31'd0, axi_r_payload_id}, {31'd0, rx.id});
        end
      end
      if (axi_b_valid && axi_b_ready) begin
        if (b_q.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else begin
          bx = b_q.pop_front();
          check("b_id", {31'd0, axi_b_payload_id}, {31'd0, bx});
        end
      end
      if (ram_en && !ram_wr) occ++;
      if (axi_r_valid && axi_r_ready) occ--;
      if (occ > max_occ) max_occ = occ;
    end
  end

  // r_ready pattern 1,0,0,1 when toggling, otherwise always ready
  initial begin
    int k;
    k = 0;
    axi_r_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axi_r_ready = rr_toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      k++;
    end
  end

  task automatic arw(input logic [13:0] a, input logic id, input logic [7:0] len,
                     input logic [1:0] burst, input logic wr);
    int n;
    axi_arw_valid = 1'b1;
    axi_arw_payload_addr = a;
    axi_arw_payload_id = id;
    axi_arw_payload_len = len;
    axi_arw_payload_burst = burst;
    axi_arw_payload_write = wr;
    n = 0;
    @(negedge clk);
    while (!axi_arw_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!axi_arw_ready) check("arw_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    axi_arw_valid = 1'b0;
  endtask

  task automatic do_write(input logic [13:0] a, input logic id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb);
    int n;
    arw(a, id, len, burst, 1'b1);
    b_q.push_back(id);
    for (int i = 0; i <= int'(len); i++) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) shadow[wa[i]][8*b +: 8] = wd[i][8*b +: 8];
      ram_q.push_back('{1'b1, wa[i], strb, wd[i]});
      axi_w_valid = 1'b1;
      axi_w_payload_data = wd[i];
      axi_w_payload_strb = strb;
      axi_w_payload_last = (i == int'(len));
      n = 0;
      @(negedge clk);
      while (!axi_w_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!axi_w_ready) check("w_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end
    axi_w_valid = 1'b0;
    axi_w_payload_last = 1'b0;
    @(negedge clk);
    check("b_valid_latency", {31'd0, axi_b_valid}, 32'd1);
    n = 0;
    while (b_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b_done", b_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic id, input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      ram_q.push_back('{1'b0, wa[i], 4'hF, 32'd0});
      r_q.push_back('{shadow[wa[i]], (i == int'(len)), id});
    end
  endtask

  task automatic do_read(input logic [13:0] a, input logic id, input logic [7:0] len,
                         input logic [1:0] burst, input bit chk_lat);
    int n;
    push_read(id, len);
    arw(a, id, len, burst, 1'b0);
    if (chk_lat) begin
      @(posedge clk);
      @(negedge clk);
      check("r_valid_not_yet", {31'd0, axi_r_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("r_valid_first", {31'd0, axi_r_valid}, 32'd1);
    end
    n = 0;
    while ((r_q.size() != 0 || ram_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("read_done_r", r_q.size(), 32'd0);
    check("read_done_ram", ram_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = 32'hA000_0000 + i;
      shadow[i] = 32'hA000_0000 + i;
    end
    reset = 1'b0;
    axi_arw_valid = 1'b0;
    axi_arw_payload_addr = '0;
    axi_arw_payload_id = 1'b0;
    axi_arw_payload_len = '0;
    axi_arw_payload_size = 3'd2;
    axi_arw_payload_burst = 2'b01;
    axi_arw_payload_write = 1'b0;
    axi_w_valid = 1'b0;
    axi_w_payload_data = '0;
    axi_w_payload_strb = '0;
    axi_w_payload_last = 1'b0;
    axi_b_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arw_ready", {31'd0, axi_arw_ready}, 32'd1);
    check("rst_b_valid", {31'd0, axi_b_valid}, 32'd0);
    check("rst_r_valid", {31'd0, axi_r_valid}, 32'd0);
    check("rst_w_ready", {31'd0, axi_w_ready}, 32'd0);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    wa = '{12'h800, 12'h801, 12'h802, 12'h803, 12'h0, 12'h0, 12'h0, 12'h0};
    wd = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 0, 0, 0, 0};
    do_write(14'h2000, 1'b1, 8'd3, 2'b01, 4'hF);

    do_read(14'h2000, 1'b0, 8'd3, 2'b01, 1'b1);

    wa = '{12'h802, 12'h803, 12'h800, 12'h801, 12'h0, 12'h0, 12'h0, 12'h0};
    do_read(14'h2008, 1'b1, 8'd3, 2'b10, 1'b1);

    wa = '{12'h801, 12'h800, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
    do_read(14'h2004, 1'b0, 8'd1, 2'b10, 1'b0);

    wa = '{12'h800, 12'h801, 12'h802, 12'h803, 12'h804, 12'h805, 12'h806, 12'h807};
    rr_toggle = 1'b1;
    max_occ = 0;
    do_read(14'h2000, 1'b1, 8'd7, 2'b01, 1'b0);
    rr_toggle = 1'b0;
    check("max_outstanding", max_occ, 32'd2);

    wa = '{12'hFFF, 12'hFFF, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
    wd = '{32'hAABB_CCDD, 32'h5566_7788, 0, 0, 0, 0, 0, 0};
    do_write(14'h3FFC, 1'b0, 8'd1, 2'b00, 4'b0101);
    do_read(14'h3FFC, 1'b1, 8'd0, 2'b00, 1'b0);
    check("masked_word", shadow[12'hFFF], 32'hA066_0F88);

    wa = '{12'hFFF, 12'h000, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
    wd = '{32'hD1D1_D1D1, 32'hD2D2_D2D2, 0, 0, 0, 0, 0, 0};
    do_write(14'h3FFC, 1'b1, 8'd1, 2'b01, 4'hF);
    do_read(14'h3FFC, 1'b0, 8'd1, 2'b01, 1'b0);

    wa = '{12'h800, 12'h801, 12'h802, 12'h803, 12'h804, 12'h805, 12'h806, 12'h807};
    base = r_pops;
    push_read(1'b0, 8'd7);
    arw(14'h2000, 1'b0, 8'd7, 2'b01, 1'b0);
    n = 0;
    while (r_pops < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_beats", r_pops - base, 32'd2);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_r_valid", {31'd0, axi_r_valid}, 32'd0);
    check("midrst_arw_ready", {31'd0, axi_arw_ready}, 32'd1);
    check("midrst_ram_en", {31'd0, ram_en}, 32'd0);
    ram_q.delete();
    r_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wa = '{12'h802, 12'h803, 12'h804, 12'h805, 12'h0, 12'h0, 12'h0, 12'h0};
    do_read(14'h2008, 1'b1, 8'd3, 2'b01, 1'b1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axi_ram_initiator.md
Name: axi_ram_initiator

Overview:
AXI-style slave front end that masters the single-port, byte-masked on-chip RAM port (en/wr/addr/mask/wrData/rdData, 1-cycle read latency). It converts shared-address-channel AXI bursts (INCR, WRAP, FIXED) into one RAM access per beat, with read-side backpressure buffering. It sits between the CPU interconnect and the 16 KB internal RAM/BIOS ROM. ROM write protection stays in the RAM; this block passes all writes through.

Parameters:
ADDR_BITS, 14, AXI byte-address width.
RAM_ADDR_BITS, 12, RAM word-address width; must equal ADDR_BITS-2.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset (0 = in reset)
axi_arw_valid  input  1  address request valid
axi_arw_ready  output  1  address request accepted
axi_arw_payload_addr  input  ADDR_BITS  burst start byte address
axi_arw_payload_id  input  1  transaction id
axi_arw_payload_len  input  8  beats minus one
axi_arw_payload_size  input  3  beat size; only 2 (4 bytes) supported
axi_arw_payload_burst  input  2  00 FIXED, 01 INCR, 10 WRAP
axi_arw_payload_write  input  1  1 = write burst, 0 = read burst
axi_w_valid  input  1  write beat valid
axi_w_ready  output  1  write beat accepted
axi_w_payload_data  input  32  write data
axi_w_payload_strb  input  4  byte strobes
axi_w_payload_last  input  1  last write beat (informational)
axi_b_valid  output  1  write response valid
axi_b_ready  input  1  write response accepted
axi_b_payload_id  output  1  id of completed write
axi_r_valid  output  1  read beat valid
axi_r_ready  input  1  read beat accepted
axi_r_payload_data  output  32  read data
axi_r_payload_id  output  1  id of read burst
axi_r_payload_last  output  1  final read beat
ram_en  output  1  RAM access enable
ram_wr  output  1  RAM write
ram_addr  output  RAM_ADDR_BITS  RAM word address
ram_mask  output  4  RAM byte enables
ram_wrData  output  32  RAM write data
ram_rdData  input  32  RAM read data, valid the cycle after ram_en & !ram_wr

Behaviour:
- States: IDLE, WRITE, WRITE_RESP, READ. Reset state IDLE; all counters, FIFO and latched id/addr cleared. Reset mid-burst abandons the transaction; no response is issued.
- Reset output values: axi_b_valid=0, axi_r_valid=0, axi_w_ready=0, ram_en=0, ram_wr=0, axi_arw_ready=1 (axi_arw_ready = state==IDLE).
- IDLE: on arw handshake, latch addr, id, len, and burst mode; clear beat counter. Go to WRITE if write=1, else READ. size is ignored and treated as 2.
- Address step per beat: INCR adds 4 and wraps modulo 2^ADDR_BITS. FIXED keeps the address unchanged. WRAP applies only for len in {1,3,7,15}: the address wraps within an aligned (len+1)*4-byte window. WRAP with any other len behaves as INCR. ram_addr = current addr[ADDR_BITS-1:2].
- WRITE: axi_w_ready=1. ram_en=ram_wr=axi_w_valid, combinational, with mask=strb and wrData=data in the same cycle. Each handshake increments the beat counter. After beat len+1, go to WRITE_RESP. axi_w_payload_last does not end the burst; only the counter does.
- WRITE_RESP: axi_b_valid=1, b_id=latched id. On b_ready, go to IDLE. Minimum write latency: b_valid is asserted the cycle after the last w handshake.
- READ: a 2-entry output FIFO holds {data,last}, plus a 1-bit inflight flag meaning a RAM read was issued last cycle.
  - Issue (ram_en=1, ram_wr=0, mask=4'hF) when issued beats ≤ len and fifo_count+inflight < 2, counting the pop in the same cycle as freeing space.
  - One cycle after issue, push ram_rdData into the FIFO. last = (beat index == len).
  - axi_r_valid = FIFO non-empty; head supplies data/last; r_id = latched id.
  - After the pop of the beat with last=1, go to IDLE. A new arw can be accepted in the next cycle.
- Throughput: 1 beat/cycle sustained for both read and write while the sink is ready. First read data appears 2 cycles after the arw handshake.
- Only one burst is outstanding at a time; no read/write overlap.

Test Plan:
- Write INCR addr=0x2000 len=3 data 0x11..,0x22..,0x33..,0x44.. strb=F, w_valid continuous -> ram_en/wr on 4 consecutive cycles at word addr 0x800–0x803; b_valid the next cycle with matching id.
- Read INCR addr=0x2000 len=3, r_ready=1 -> ram reads at 0x800–0x803; r data in order, r_last only on beat 4, r_valid first seen 2 cycles after arw.
- Read WRAP addr=0x2008 len=3 -> word addresses 0x802,0x803,0x800,0x801.
- Read len=7 with r_ready toggled 1,0,0,1,… -> no data lost or duplicated; FIFO never exceeds 2; ram_en stalls while full.
- Write strb=4'b0101 FIXED addr=0x3FFC len=1 -> two RAM writes at word 0xFFF, mask 0101 both times; INCR at 0x3FFC len=1 wraps to word 0x000.
- Assert reset mid-read at beat 2 -> r_valid=0, arw_ready=1 immediately; after release, a new read completes normally.
